// File: rtl/statusbar_ctrl.sv
// Status-line owner: arbitrates clear/score/char updates into a shadow line and
// copies shadow to the visible line only on frame boundaries.
module statusbar_ctrl #(
    parameter int NCHARS    = 36,
    parameter int SCORE_POS = 6
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     vsync_pulse_i,
    input  logic                     clear_req_i,
    input  logic                     score_req_i,
    input  logic [15:0]              score_val_i,
    input  logic                     char_req_i,
    input  logic [5:0]               char_idx_i,
    input  logic [7:0]               char_data_i,
    output logic                     clear_ack_o,
    output logic                     score_ack_o,
    output logic                     char_ack_o,
    output logic                     busy_o,
    output logic [0:NCHARS-1][7:0]   status_array_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_CONV,
        S_WRDIG,
        S_CHAR
    } state_t;

    function automatic logic [0:NCHARS-1][7:0] make_template();
        logic [0:NCHARS-1][7:0] t;
        for (int i = 0; i < NCHARS; i++) t[i] = 8'h20;
        t[0] = 8'h53;
        t[1] = 8'h43;
        t[2] = 8'h4F;
        t[3] = 8'h52;
        t[4] = 8'h45;
        for (int i = 0; i < 5; i++) t[SCORE_POS+i] = 8'h30;
        return t;
    endfunction

    localparam logic [0:NCHARS-1][7:0] TEMPLATE = make_template();

    function automatic logic [19:0] dabble_adj(input logic [19:0] b);
        logic [19:0] r;
        r = b;
        for (int n = 0; n < 5; n++) begin
            if (b[4*n +: 4] >= 4'd5) r[4*n +: 4] = b[4*n +: 4] + 4'd3;
        end
        return r;
    endfunction

    state_t                   state_q;
    logic [0:NCHARS-1][7:0]   shadow_q;
    logic [0:NCHARS-1][7:0]   visible_q;
    logic                     copy_pending_q;
    logic                     clear_ack_q, score_ack_q, char_ack_q;
    logic [5:0]               cnt_q;
    logic [35:0]              conv_q;
    logic [35:0]              conv_d;
    logic [5:0]               cap_idx_q;
    logic [7:0]               cap_data_q;
    logic [3:0]               digit;
    logic [5:0]               dig_idx;

    always_comb begin
        conv_d = {dabble_adj(conv_q[35:16]), conv_q[15:0]} << 1;
    end

    // After 16 iterations the BCD result sits in conv_q[35:16], MS digit on top.
    always_comb begin
        case (cnt_q[2:0])
            3'd0:    digit = conv_q[35:32];
            3'd1:    digit = conv_q[31:28];
            3'd2:    digit = conv_q[27:24];
            3'd3:    digit = conv_q[23:20];
            default: digit = conv_q[19:16];
        endcase
        dig_idx = 6'(SCORE_POS) + cnt_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= S_IDLE;
            shadow_q       <= TEMPLATE;
            visible_q      <= TEMPLATE;
            copy_pending_q <= 1'b0;
            clear_ack_q    <= 1'b0;
            score_ack_q    <= 1'b0;
            char_ack_q     <= 1'b0;
            cnt_q          <= '0;
            conv_q         <= '0;
            cap_idx_q      <= '0;
            cap_data_q     <= '0;
        end else begin
            clear_ack_q <= 1'b0;
            score_ack_q <= 1'b0;
            char_ack_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // A req whose ack is still showing is the completed one, not a new one.
                    if (clear_req_i && !clear_ack_q) begin
                        state_q <= S_CLEAR;
                        cnt_q   <= '0;
                    end else if (score_req_i && !score_ack_q) begin
                        state_q <= S_CONV;
                        cnt_q   <= '0;
                        conv_q  <= {20'd0, score_val_i};
                    end else if (char_req_i && !char_ack_q) begin
                        state_q    <= S_CHAR;
                        cap_idx_q  <= char_idx_i;
                        cap_data_q <= char_data_i;
                    end
                end
                S_CLEAR: begin
                    shadow_q[cnt_q] <= 8'h20;
                    if (cnt_q == 6'(NCHARS - 1)) begin
                        state_q     <= S_IDLE;
                        clear_ack_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 6'd1;
                    end
                end
                S_CONV: begin
                    conv_q <= conv_d;
                    if (cnt_q == 6'd15) begin
                        state_q <= S_WRDIG;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 6'd1;
                    end
                end
                S_WRDIG: begin
                    shadow_q[dig_idx] <= {4'h3, digit};
                    if (cnt_q == 6'd4) begin
                        state_q     <= S_IDLE;
                        score_ack_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 6'd1;
                    end
                end
                S_CHAR: begin
                    if (cap_idx_q < 6'(NCHARS)) shadow_q[cap_idx_q] <= cap_data_q;
                    state_q    <= S_IDLE;
                    char_ack_q <= 1'b1;
                end
                default: state_q <= S_IDLE;
            endcase

            // Shadow is never written in IDLE, so copying here is always a whole line.
            if (state_q == S_IDLE) begin
                if (vsync_pulse_i || copy_pending_q) begin
                    visible_q      <= shadow_q;
                    copy_pending_q <= 1'b0;
                end
            end else if (vsync_pulse_i) begin
                copy_pending_q <= 1'b1;
            end
        end
    end

    assign clear_ack_o    = clear_ack_q;
    assign score_ack_o    = score_ack_q;
    assign char_ack_o     = char_ack_q;
    assign busy_o         = (state_q != S_IDLE);
    assign status_array_o = visible_q;

endmodule

// File: doc/statusbar_ctrl.md
# statusbar_ctrl

Owns the 36-character ASCII status line that the status-bar text mapper renders, and arbitrates updates to it from game logic. Three requesters (clear, score, single-character write) modify a shadow copy. The shadow is copied to the visible array only at frame boundaries, so the renderer never shows a half-written line. Score values arrive in binary and are converted to five ASCII decimal digits by a sequential double-dabble converter.

## Interface
- NCHARS, 36, number of character slots; fixed width of status_array.
- SCORE_POS, 6, index of the most significant score digit; digits occupy SCORE_POS..SCORE_POS+4.
- Clk  input  1  system clock; all state changes on the rising edge.
- Reset  input  1  asynchronous, active-high.
- vsync_pulse  input  1  one-cycle frame-start strobe.
- clear_req  input  1  level request: blank all slots.
- score_req  input  1  level request: write score_val as 5 decimal digits.
- score_val  input  16  binary score, 0..65535.
- char_req  input  1  level request: write one character.
- char_idx  input  6  target slot for char_req.
- char_data  input  8  ASCII code for char_req.
- clear_ack, score_ack, char_ack  output  1 each  one-cycle completion pulses.
- busy  output  1  high when the FSM is not in IDLE.
- status_array  output  [0:35][7:0]  visible line, slot 0 leftmost; registered.

## Operation
- Reset template, applied to both shadow and visible arrays:
  - slots 0..4 = "SCORE" (0x53 0x43 0x4F 0x52 0x45);
  - SCORE_POS..SCORE_POS+4 = 0x30;
  - all other slots = 0x20.
- Reset also forces: acks 0, busy 0, copy_pending 0, FSM in IDLE.
- FSM states and transitions:
  - IDLE → CLEAR / CONV / CHAR on a grant.
  - CLEAR → IDLE after the last slot is written.
  - CONV → WRDIG after 16 cycles.
  - WRDIG → IDLE after 5 cycles.
  - CHAR → IDLE after 1 cycle.
- Arbitration is evaluated only in IDLE. Fixed priority: clear > score > char.
- A request whose own ack is high in the current cycle is ignored for that cycle. The requester must drop req on the cycle after its ack; a req still high one cycle later is a new request.
- Request operands (score_val, char_idx, char_data) are captured at the grant edge. Later changes have no effect on the operation in progress.
- CLEAR: writes 0x20 to shadow slot 0, 1, ..., 35, one slot per cycle (36 cycles). The "SCORE" label is blanked as well.
- CONV: a 36-bit register {20-bit BCD, 16-bit binary} is loaded at grant. Each cycle: add 3 to every BCD nibble that is ≥5, then shift left 1. This runs 16 iterations.
- WRDIG: writes the 5 BCD digits + 0x30 to SCORE_POS..SCORE_POS+4, most significant first, one per cycle. Leading zeros are written as 0x30.
- CHAR: writes char_data to shadow[char_idx]. If char_idx ≥ 36, nothing is written, but the request is still acked.
- Frame copy rules:
  - vsync_pulse in IDLE: visible ← shadow at that edge.
  - vsync_pulse while busy: set copy_pending. The copy happens at the first edge at which the state is IDLE, then copy_pending clears.
  - Multiple vsyncs while busy collapse into a single copy.
- The shadow is never written in the IDLE state. A copy and a new grant on the same IDLE edge are both performed; the copy reflects the pre-grant shadow.

## Timing
- Grant edge = edge G at which IDLE samples the winning req. busy is high from G until the FSM returns to IDLE.
- char: write occurs at G+1; char_ack is high for the cycle after G+1.
- score: CONV occupies edges G+1..G+16, WRDIG occupies G+17..G+21; score_ack is high for the cycle after G+21.
- clear: slot writes occur at G+1..G+36; clear_ack is high for the cycle after G+36.
- Each ack is registered and high for exactly one cycle, coincident with the FSM being back in IDLE.
- Visible-array latency: an update appears on status_array after the first vsync edge at which the FSM is idle, following completion.
- Reset asserted mid-operation: immediate return to the template; the in-flight operation is dropped without an ack.

## Test plan
- Reset, then one vsync → status_array = "SCORE 00000" followed by 25 × 0x20; busy = 0; all acks = 0.
- score_req with score_val = 16'd12345 → score_ack 22 cycles after the grant edge; after the next vsync, slots 6..10 = 0x31 0x32 0x33 0x34 0x35. Repeat with 65535 (0x36 0x35 0x35 0x33 0x35) and 0 (all 0x30).
- clear_req, score_req and char_req asserted in the same cycle → clear_ack first, then score_ack, then char_ack. Final line: all 0x20 except the score digits and the char slot.
- char_req with char_idx = 40 → char_ack after 2 cycles; shadow unchanged. char_req with idx = 35, data = 0x41 → slot 35 = 'A' after vsync.
- vsync_pulse at cycle 5 of a score update → status_array unchanged during the update; copy occurs on the edge the FSM re-enters IDLE, showing the new digits.
- Reset pulsed at cycle 10 of a clear → template restored immediately, no clear_ack, busy = 0.
